sram_load_ctrl: RTL
===================

Name: sram_load_ctrl

Overview:
- Upstream sequencer for the SRAM accumulate path.
- Accepts a framed word stream over a valid/ready handshake and writes it into the word SRAM at ascending addresses.
- Then drives the read-back control (first, SRAM_re, addr_minus_en, sel) so the read/accumulate stage walks the frame from last address down to 0.
- Pulses done once the accumulated sum S is settled downstream.

Parameters:
- DW, 32, data word width.
- AW, 9, SRAM address width.
- DEPTH, 512, SRAM words; must equal 2**AW.
- RD_LAT, 3, cycles from the final read strobe until S is valid downstream.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_data  in  DW  input word.
- in_last  in  1  marks the final word of a frame.
- in_ready  out  1  loader can accept a word.
- SRAM_we  out  1  SRAM write strobe.
- waddr  out  AW  SRAM write address; holds the last written address during read-back.
- din  out  DW  SRAM write data.
- sel  out  1  0 = write path owns SRAM, 1 = read path owns SRAM.
- first  out  1  one-cycle pulse: downstream loads its read pointer from waddr.
- SRAM_re  out  1  SRAM read strobe.
- addr_minus_en  out  1  downstream read pointer decrement enable.
- frame_len  out  AW+1  word count of the last completed frame.
- done  out  1  one-cycle pulse: S is valid.
- ovf  out  1  sticky: a frame hit DEPTH words without in_last.

Behaviour:
- Reset values: all outputs 0, except in_ready=1. State is IDLE, counters are 0.
  - Reset mid-frame or mid-read aborts immediately; there is no partial done.
  - ovf clears only on reset.
- All outputs are registered.
- Handshake: a word is accepted on any cycle with in_valid & in_ready.
- Write timing: accept at edge t gives SRAM_we=1, din=word, waddr=count at t+1.
  - The first word of a frame goes to address 0; addresses increment by 1.
- in_ready is 1 in IDLE and LOAD only.
  - It drops in the cycle after in_last is accepted, or after the DEPTH-th word is accepted.
- States and transitions:
  - IDLE: waits for an accept. On accept: write address 0, wcnt=1, go to LOAD; if in_last is set on that word, go to TURN instead.
  - LOAD: each accept writes the next address and increments wcnt. Idle cycles (in_valid=0) are allowed and produce SRAM_we=0. Accept with in_last, or wcnt reaching DEPTH: go to TURN.
    - Reaching DEPTH without in_last sets ovf; the frame is treated as terminated at DEPTH words.
  - TURN: exactly one cycle. SRAM_we=0, sel goes 1. frame_len=wcnt is latched.
  - RD_FIRST: one cycle. first=1, SRAM_re=1, addr_minus_en=0. Go to RD_STEP if frame_len>1, otherwise to FLUSH.
  - RD_STEP: SRAM_re=1, addr_minus_en=1 for exactly frame_len-1 cycles, then go to FLUSH.
  - FLUSH: RD_LAT cycles with SRAM_re=0, then go to DONE.
  - DONE: one cycle, done=1. sel returns to 0, in_ready=1, then IDLE.
- Width and counter rules:
  - wcnt and frame_len are AW+1 bits, so DEPTH=512 is representable.
  - waddr never wraps within a frame.
  - The read-step counter is AW+1 bits.
- Simultaneous events:
  - in_valid during TURN through DONE is ignored, because in_ready=0.
  - A word presented in the DONE cycle is not accepted until IDLE.
- Timing from in_last accept to done: 1 (write) + 1 (TURN) + 1 (RD_FIRST) + (frame_len-1) + RD_LAT + 1 cycles.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, LOAD, TURN, RD_FIRST, RD_STEP, FLUSH, DONE);
  - the DW, AW and DEPTH defaults;
  - the RD_LAT constant.
- Sub-module: ld_counter, a loadable up/down counter with terminal-count flag. It is used for both the write count and the read-step/flush count.

Test Plan:
- Frame of 4 words 0x1,0x2,0x3,0x4, in_last on the 4th, back-to-back valid -> SRAM_we on addresses 0..3 with matching din.
  - Then 1 TURN cycle, first pulse with waddr=3, exactly 3 addr_minus_en cycles.
  - frame_len=4; done 3 cycles after the last strobe plus 1 (RD_LAT=3). ovf=0.
- Single word 0xDEADBEEF with in_last -> write to address 0, first pulse, zero addr_minus_en cycles, done; frame_len=1.
- Frame of 3 words with in_valid gaps (valid 1,0,0,1,0,1) -> only 3 write strobes, addresses 0,1,2; total done latency grows by the gap count only.
- 512 words with no in_last -> in_ready drops after the 512th accept; ovf=1; frame_len=512; 511 addr_minus_en cycles; done pulses.
  - A following 2-word frame completes normally; ovf stays 1.
- rst_n asserted during RD_STEP of a 10-word frame -> all outputs go to 0 immediately and asynchronously, in_ready=1, no done.
  - A new 2-word frame afterwards writes from address 0.
- in_valid held high through TURN..DONE with a new frame pending -> no accepts until IDLE; the new frame's first word is written to address 0.

Source files
------------

// File: rtl/sram_load_ctrl_pkg.sv
// Shared types and defaults for the SRAM load/read-back sequencer.
package sram_load_ctrl_pkg;

    localparam int unsigned DEF_DW    = 32;
    localparam int unsigned DEF_AW    = 9;
    localparam int unsigned DEF_DEPTH = 512;
    localparam int unsigned RD_LAT    = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        TURN,
        RD_FIRST,
        RD_STEP,
        FLUSH,
        DONE
    } state_t;

endpackage

// File: rtl/sram_load_ctrl_counter.sv
// Loadable up/down counter with a compare-based terminal-count flag.
module ld_counter #(
    parameter int unsigned W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         up,
    input  logic [W-1:0] tc_val,
    output logic [W-1:0] cnt,
    output logic         tc_c
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= up ? cnt + W'(1) : cnt - W'(1);
        end
    end

    assign tc_c = (cnt == tc_val);

endmodule

// File: rtl/sram_load_ctrl.sv
// Loads a framed word stream into the word SRAM, then sequences the
// descending read-back and signals when the downstream sum has settled.
module sram_load_ctrl
    import sram_load_ctrl_pkg::*;
#(
    parameter int unsigned DW    = DEF_DW,
    parameter int unsigned AW    = DEF_AW,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          in_ready,
    output logic          SRAM_we,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] din,
    output logic          sel,
    output logic          first,
    output logic          SRAM_re,
    output logic          addr_minus_en,
    output logic [AW:0]   frame_len,
    output logic          done,
    output logic          ovf
);

    localparam int unsigned CW = AW + 1;

    state_t          state, state_nx;
    logic            accept;
    logic            w_load, w_en, r_load, r_en, set_ovf;
    logic [CW-1:0]   wcnt, rcnt, r_load_val;
    logic            wcnt_tc, rcnt_tc;

    assign accept = in_valid & in_ready;

    // Words accepted so far in the current frame.
    ld_counter #(.W(CW)) u_wcnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .load_val (CW'(1)),
        .en       (w_en),
        .up       (1'b1),
        .tc_val   (CW'(DEPTH - 1)),
        .cnt      (wcnt),
        .tc_c     (wcnt_tc)
    );

    // Remaining read-step cycles, then reused for the flush wait.
    ld_counter #(.W(CW)) u_rcnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (r_load),
        .load_val (r_load_val),
        .en       (r_en),
        .up       (1'b0),
        .tc_val   (CW'(1)),
        .cnt      (rcnt),
        .tc_c     (rcnt_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        w_load     = 1'b0;
        w_en       = 1'b0;
        r_load     = 1'b0;
        r_en       = 1'b0;
        r_load_val = '0;
        set_ovf    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    w_load   = 1'b1;
                    state_nx = in_last ? TURN : LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    w_en = 1'b1;
                    if (in_last) begin
                        state_nx = TURN;
                    end else if (wcnt_tc) begin
                        state_nx = TURN;
                        set_ovf  = 1'b1;
                    end
                end
            end
            TURN: state_nx = RD_FIRST;
            RD_FIRST: begin
                r_load = 1'b1;
                if (frame_len > CW'(1)) begin
                    state_nx   = RD_STEP;
                    r_load_val = frame_len - CW'(1);
                end else begin
                    state_nx   = FLUSH;
                    r_load_val = CW'(RD_LAT);
                end
            end
            RD_STEP: begin
                if (rcnt_tc) begin
                    state_nx   = FLUSH;
                    r_load     = 1'b1;
                    r_load_val = CW'(RD_LAT);
                end else begin
                    r_en = 1'b1;
                end
            end
            FLUSH: begin
                if (rcnt_tc) begin
                    state_nx = DONE;
                end else begin
                    r_en = 1'b1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Read-side controls show each state's decode one cycle later, so the
    // last write strobe gets its own cycle before the turnaround.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready      <= 1'b1;
            SRAM_we       <= 1'b0;
            waddr         <= '0;
            din           <= '0;
            sel           <= 1'b0;
            first         <= 1'b0;
            SRAM_re       <= 1'b0;
            addr_minus_en <= 1'b0;
            frame_len     <= '0;
            done          <= 1'b0;
            ovf           <= 1'b0;
        end else begin
            in_ready      <= (state_nx == IDLE) || (state_nx == LOAD);
            SRAM_we       <= accept;
            if (accept) begin
                din   <= in_data;
                waddr <= (state == IDLE) ? '0 : wcnt[AW-1:0];
            end
            sel           <= (state == TURN) || (state == RD_FIRST) ||
                             (state == RD_STEP) || (state == FLUSH);
            first         <= (state == RD_FIRST);
            SRAM_re       <= (state == RD_FIRST) || (state == RD_STEP);
            addr_minus_en <= (state == RD_STEP);
            done          <= (state == DONE);
            if (state == TURN) begin
                frame_len <= wcnt;
            end
            if (set_ovf) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule
